// File: rtl/eth_mac_rx_frame_buffer.sv
// Store-and-forward RX frame buffer behind the GMII MAC: commits whole frames, drops bad/overflowing ones.
// Optional 32-bit saturating frame counters are enabled with ETH_RX_FRAME_BUFFER_STATS_EN.
module eth_mac_rx_frame_buffer #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
  output logic [31:0] stat_good_count,
  output logic [31:0] stat_bad_count,
  output logic [31:0] stat_overflow_count,
`endif
  output logic        status_good_frame,
  output logic        status_bad_frame,
  output logic        status_overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic [0:0] {ST_WRITE, ST_DROP} wr_state_t;

  // Output stream: a beat transfers on a cycle where m_axis_tvalid and m_axis_tready are both high;
  // while m_axis_tvalid is high and m_axis_tready is low, tdata/tlast/tuser hold their values.
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic [PW-1:0] wr_ptr_cur_nxt, wr_ptr_commit_nxt;
  wr_state_t     state, state_nxt;
  logic          wr_en, good_nxt, bad_nxt, ovf_nxt;
  logic          full, empty;

  assign full  = (wr_ptr_cur - rd_ptr) == PW'(DEPTH);
  assign empty = (rd_ptr == wr_ptr_commit);

  always_comb begin
    state_nxt         = state;
    wr_ptr_cur_nxt    = wr_ptr_cur;
    wr_ptr_commit_nxt = wr_ptr_commit;
    wr_en             = 1'b0;
    good_nxt          = 1'b0;
    bad_nxt           = 1'b0;
    ovf_nxt           = 1'b0;
    case (state)
      ST_WRITE: begin
        if (s_axis_tvalid) begin
          if (full) begin
            wr_ptr_cur_nxt = wr_ptr_commit;
            ovf_nxt        = 1'b1;
            if (!s_axis_tlast) state_nxt = ST_DROP;
          end else if (s_axis_tlast && s_axis_tuser && DROP_BAD_FRAME) begin
            wr_ptr_cur_nxt = wr_ptr_commit;
            bad_nxt        = 1'b1;
          end else begin
            wr_en          = 1'b1;
            wr_ptr_cur_nxt = wr_ptr_cur + PW'(1);
            if (s_axis_tlast) begin
              wr_ptr_commit_nxt = wr_ptr_cur + PW'(1);
              good_nxt          = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_WRITE;
      end
      default: state_nxt = ST_WRITE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_WRITE;
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      state             <= state_nxt;
      wr_ptr_cur        <= wr_ptr_cur_nxt;
      wr_ptr_commit     <= wr_ptr_commit_nxt;
      status_good_frame <= good_nxt;
      status_bad_frame  <= bad_nxt;
      status_overflow   <= ovf_nxt;
    end
  end

  // tuser is only meaningful on the last beat, so it is masked before storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast & s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end

  // Read pipeline: the synchronous RAM read lands in a skid stage, which feeds the output register.
  logic [9:0] skid_word;
  logic       skid_valid, skid_move, rd_en, user_q;

  assign skid_move = skid_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_en     = !empty && (!skid_valid || skid_move);

  always_ff @(posedge clk) begin
    if (rd_en) skid_word <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      skid_valid    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      user_q        <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr     <= rd_ptr + PW'(1);
        skid_valid <= 1'b1;
      end else if (skid_move) begin
        skid_valid <= 1'b0;
      end
      if (skid_move) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= skid_word[7:0];
        m_axis_tlast  <= skid_word[8];
        user_q        <= skid_word[9];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tuser = DROP_BAD_FRAME ? 1'b0 : user_q;

`ifdef ETH_RX_FRAME_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_good_count     <= '0;
      stat_bad_count      <= '0;
      stat_overflow_count <= '0;
    end else begin
      if (status_good_frame && stat_good_count != 32'hFFFF_FFFF) stat_good_count <= stat_good_count + 32'd1;
      if (status_bad_frame && stat_bad_count != 32'hFFFF_FFFF) stat_bad_count <= stat_bad_count + 32'd1;
      if (status_overflow && stat_overflow_count != 32'hFFFF_FFFF)
        stat_overflow_count <= stat_overflow_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_mac_rx_frame_buffer.sv
// Directed bench for eth_mac_rx_frame_buffer: three instances (default, 64-byte depth, bad-frame forwarding).
module tb_eth_mac_rx_frame_buffer;

  logic       clk, rst;
  logic [7:0] s_data [3];
  logic       s_valid [3], s_last [3], s_user [3];
  logic [7:0] m_data [3];
  logic       m_valid [3], m_last [3], m_user [3], ready [3];
  logic       st_good [3], st_bad [3], st_ovf [3];

  logic [9:0] exp_q [3][$];
  int checks, errors;
  int rx_cnt [3], good_cnt [3], bad_cnt [3], ovf_cnt [3], user_cnt [3];
  logic       prev_stall [3];
  logic [9:0] prev_word [3];
  bit         rand_on;

  eth_mac_rx_frame_buffer #(.ADDR_WIDTH(12), .DROP_BAD_FRAME(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tlast(s_last[0]), .s_axis_tuser(s_user[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(ready[0]),
    .m_axis_tlast(m_last[0]), .m_axis_tuser(m_user[0]),
    .status_good_frame(st_good[0]), .status_bad_frame(st_bad[0]), .status_overflow(st_ovf[0]));

  eth_mac_rx_frame_buffer #(.ADDR_WIDTH(6), .DROP_BAD_FRAME(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tlast(s_last[1]), .s_axis_tuser(s_user[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(ready[1]),
    .m_axis_tlast(m_last[1]), .m_axis_tuser(m_user[1]),
    .status_good_frame(st_good[1]), .status_bad_frame(st_bad[1]), .status_overflow(st_ovf[1]));

  eth_mac_rx_frame_buffer #(.ADDR_WIDTH(12), .DROP_BAD_FRAME(1'b0)) u2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data[2]), .s_axis_tvalid(s_valid[2]), .s_axis_tlast(s_last[2]), .s_axis_tuser(s_user[2]),
    .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(ready[2]),
    .m_axis_tlast(m_last[2]), .m_axis_tuser(m_user[2]),
    .status_good_frame(st_good[2]), .status_bad_frame(st_bad[2]), .status_overflow(st_ovf[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one beat per cycle, starting just after a rising edge
  task automatic send(input int idx, input int len, input bit bad, input bit keep, input int seed,
                      input int ovf_at);
    logic [9:0] w;
    for (int i = 0; i < len; i++) begin
      w = {bad && (i == len - 1), i == len - 1, 8'(seed * 13 + i)};
      s_valid[idx] = 1'b1;
      s_data[idx]  = w[7:0];
      s_last[idx]  = w[8];
      s_user[idx]  = w[9];
      if (keep) exp_q[idx].push_back(w);
      @(posedge clk); #1;
      if (i == ovf_at) check($sformatf("ovf_pulse%0d", idx), 32'(st_ovf[idx]), 32'd1);
    end
    s_valid[idx] = 1'b0;
    s_last[idx]  = 1'b0;
    s_user[idx]  = 1'b0;
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    while (exp_q[idx].size() != 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("drain%0d", idx), 32'(exp_q[idx].size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (st_good[i]) good_cnt[i]++;
        if (st_bad[i]) bad_cnt[i]++;
        if (st_ovf[i]) ovf_cnt[i]++;
        if (prev_stall[i])
          check($sformatf("hold%0d", i), 32'({m_valid[i], m_user[i], m_last[i], m_data[i]}),
                32'({1'b1, prev_word[i]}));
        if (m_valid[i] && ready[i]) begin
          rx_cnt[i]++;
          if (m_user[i]) user_cnt[i]++;
          check($sformatf("beat_expected%0d", i), 32'(exp_q[i].size() != 0), 32'd1);
          if (exp_q[i].size() != 0)
            check($sformatf("beat%0d", i), 32'({m_user[i], m_last[i], m_data[i]}), 32'(exp_q[i].pop_front()));
        end
        prev_stall[i] = m_valid[i] && !ready[i];
        prev_word[i]  = {m_user[i], m_last[i], m_data[i]};
      end
    end
  end

  initial begin
    int len, n, gate_to, r, g;
    checks = 0; errors = 0; rand_on = 1'b0; gate_to = 0;
    for (int i = 0; i < 3; i++) begin
      s_data[i] = 8'h00; s_valid[i] = 1'b0; s_last[i] = 1'b0; s_user[i] = 1'b0; ready[i] = 1'b1;
      rx_cnt[i] = 0; good_cnt[i] = 0; bad_cnt[i] = 0; ovf_cnt[i] = 0; user_cnt[i] = 0;
      prev_stall[i] = 1'b0; prev_word[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), 32'(m_valid[i]), 32'd0);
      check($sformatf("rst_out%0d", i), 32'({m_user[i], m_last[i], m_data[i]}), 32'd0);
      check($sformatf("rst_status%0d", i), 32'({st_good[i], st_bad[i], st_ovf[i]}), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // 64-byte good frame with commit-to-valid latency
    send(0, 64, 1'b0, 1'b1, 1, -1);
    check("good_pulse", 32'(st_good[0]), 32'd1);
    check("lat0", 32'(m_valid[0]), 32'd0);
    @(posedge clk); #1;
    check("lat1", 32'(m_valid[0]), 32'd0);
    @(posedge clk); #1;
    check("lat2", 32'(m_valid[0]), 32'd1);
    drain(0);
    check("a_rx", 32'(rx_cnt[0]), 32'd64);
    check("a_good", 32'(good_cnt[0]), 32'd1);

    // 60-byte bad frame dropped, then a good frame
    send(0, 60, 1'b1, 1'b0, 2, -1);
    check("bad_pulse", 32'(st_bad[0]), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("b_rx", 32'(rx_cnt[0]), 32'd64);
    check("b_bad", 32'(bad_cnt[0]), 32'd1);
    check("b_good", 32'(good_cnt[0]), 32'd1);
    send(0, 100, 1'b0, 1'b1, 3, -1);
    drain(0);
    check("b2_rx", 32'(rx_cnt[0]), 32'd164);
    check("b2_good", 32'(good_cnt[0]), 32'd2);

    // 64-byte depth: 64 then 65 back-to-back with tready low
    ready[1] = 1'b0;
    send(1, 64, 1'b0, 1'b1, 4, -1);
    send(1, 65, 1'b0, 1'b0, 5, 0);
    repeat (10) @(posedge clk);
    #1;
    check("c_ovf", 32'(ovf_cnt[1]), 32'd1);
    check("c_good", 32'(good_cnt[1]), 32'd1);
    check("c_rx_stalled", 32'(rx_cnt[1]), 32'd0);
    ready[1] = 1'b1;
    drain(1);
    check("c_rx", 32'(rx_cnt[1]), 32'd64);
    check("c_idle", 32'(m_valid[1]), 32'd0);
    // exactly DEPTH into an empty buffer fits; DEPTH+1 never does
    ready[1] = 1'b0;
    send(1, 64, 1'b0, 1'b1, 6, -1);
    repeat (3) @(posedge clk);
    #1;
    check("c_depth_good", 32'(good_cnt[1]), 32'd2);
    check("c_depth_ovf", 32'(ovf_cnt[1]), 32'd1);
    ready[1] = 1'b1;
    drain(1);
    check("c_depth_rx", 32'(rx_cnt[1]), 32'd128);
    send(1, 65, 1'b0, 1'b0, 7, 64);
    repeat (5) @(posedge clk);
    #1;
    check("c_d1_ovf", 32'(ovf_cnt[1]), 32'd2);
    check("c_d1_rx", 32'(rx_cnt[1]), 32'd128);

    // forwarding instance: 70-byte bad frame goes through with tuser on the last beat
    send(2, 70, 1'b1, 1'b1, 8, -1);
    drain(2);
    check("d_rx", 32'(rx_cnt[2]), 32'd70);
    check("d_user", 32'(user_cnt[2]), 32'd1);
    check("d_good", 32'(good_cnt[2]), 32'd1);
    check("d_bad", 32'(bad_cnt[2]), 32'd0);

    // back-to-back frames with random tready
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          ready[0] = 1'($urandom_range(0, 1));
        end
        ready[0] = 1'b1;
      end
    join_none
    r = rx_cnt[0]; g = good_cnt[0];
    n = 0;
    for (int f = 0; f < 16; f++) begin
      len = (f == 0) ? 1518 : (f == 1) ? 64 : $urandom_range(64, 1518);
      n += len;
      for (int t = 0; exp_q[0].size() + len > 4000; t++) begin
        if (t >= 20000) begin gate_to++; break; end
        @(posedge clk); #1;
      end
      send(0, len, 1'b0, 1'b1, 20 + f, -1);
    end
    rand_on = 1'b0;
    drain(0);
    check("e_gate", 32'(gate_to), 32'd0);
    check("e_rx", 32'(rx_cnt[0] - r), 32'(n));
    check("e_good", 32'(good_cnt[0] - g), 32'd16);
    check("e_ovf", 32'(ovf_cnt[0]), 32'd0);

    // reset at byte 30 while a frame is buffered
    ready[0] = 1'b0;
    send(0, 200, 1'b0, 1'b1, 50, -1);
    for (int i = 0; i < 30; i++) begin
      s_valid[0] = 1'b1; s_data[0] = 8'(i); s_last[0] = 1'b0;
      if (i == 29) begin
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(m_valid[0]), 32'd0);
        exp_q[0].delete();
      end
      @(posedge clk); #1;
    end
    s_valid[0] = 1'b0;
    rst = 1'b0;
    ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_partial", 32'(m_valid[0]), 32'd0);
    r = rx_cnt[0]; g = good_cnt[0];
    send(0, 80, 1'b0, 1'b1, 60, -1);
    drain(0);
    check("f_rx", 32'(rx_cnt[0] - r), 32'd80);
    check("f_good", 32'(good_cnt[0] - g), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
